// File: rtl/con_encoder_ff_if.sv
// Signal bundle between the CON FF condition resolver and its controller.
// The controller side drives the strobe and select; the resolver returns the flag and statistics.
interface con_encoder_ff_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  con_in;
  logic [3:0]            cond_onehot;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  err_ack;
  logic                  counter_clr;
  logic                  con_out;
  logic [1:0]            cond_code;
  logic                  code_valid;
  logic                  done;
  logic                  onehot_error;
  logic [CNT_WIDTH-1:0]  taken_count;
  logic [CNT_WIDTH-1:0]  not_taken_count;

  modport master (
    output con_in, cond_onehot, bus_data, err_ack, counter_clr,
    input  con_out, cond_code, code_valid, done, onehot_error,
           taken_count, not_taken_count
  );

  modport slave (
    input  con_in, cond_onehot, bus_data, err_ack, counter_clr,
    output con_out, cond_code, code_valid, done, onehot_error,
           taken_count, not_taken_count
  );
endinterface

// File: rtl/con_encoder_ff.sv
// Two-stage CON FF resolver: captures a one-hot condition select with the bus value,
// then produces the registered branch flag, encoded condition and taken/not-taken statistics.
module con_encoder_ff #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               clear,
  con_encoder_ff_if.slave    bus
);

  // Returns {valid, code}; anything not strictly one-hot maps to {0, 00}.
  function automatic logic [2:0] encode_sel(input logic [3:0] sel);
    case (sel)
      4'b0001: encode_sel = 3'b100;
      4'b0010: encode_sel = 3'b101;
      4'b0100: encode_sel = 3'b110;
      4'b1000: encode_sel = 3'b111;
      default: encode_sel = 3'b000;
    endcase
  endfunction

  function automatic logic cond_eval(input logic [1:0] code, input logic z, input logic n);
    case (code)
      2'b00:   cond_eval = z;
      2'b01:   cond_eval = ~z;
      2'b10:   cond_eval = ~n;
      default: cond_eval = n;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [2:0] sel_enc;
  logic       vld_p0;
  logic [1:0] code_p0;
  logic       valid_p0;
  logic       z_p0;
  logic       n_p0;
  logic       take_p0;

  assign sel_enc = encode_sel(bus.cond_onehot);
  assign take_p0 = valid_p0 & cond_eval(code_p0, z_p0, n_p0);

  // Stage 1: capture select and bus flags on the CONin strobe
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      vld_p0   <= 1'b0;
      code_p0  <= 2'b00;
      valid_p0 <= 1'b0;
      z_p0     <= 1'b0;
      n_p0     <= 1'b0;
    end else begin
      vld_p0 <= bus.con_in;
      if (bus.con_in) begin
        valid_p0 <= sel_enc[2];
        code_p0  <= sel_enc[1:0];
        z_p0     <= (bus.bus_data == '0);
        n_p0     <= bus.bus_data[DATA_WIDTH-1];
      end
    end
  end

  // A new invalid capture outranks an acknowledge on the same edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bus.onehot_error <= 1'b0;
    end else if (bus.con_in && !sel_enc[2]) begin
      bus.onehot_error <= 1'b1;
    end else if (bus.err_ack) begin
      bus.onehot_error <= 1'b0;
    end
  end

  // Stage 2: resolve the condition and publish the CON flag
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bus.con_out    <= 1'b0;
      bus.cond_code  <= 2'b00;
      bus.code_valid <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= vld_p0;
      if (vld_p0) begin
        bus.con_out    <= take_p0;
        bus.cond_code  <= code_p0;
        bus.code_valid <= valid_p0;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bus.taken_count     <= '0;
      bus.not_taken_count <= '0;
    end else if (bus.counter_clr) begin
      bus.taken_count     <= '0;
      bus.not_taken_count <= '0;
    end else if (vld_p0) begin
      if (take_p0) begin
        bus.taken_count <= sat_inc(bus.taken_count);
      end else if (valid_p0) begin
        bus.not_taken_count <= sat_inc(bus.not_taken_count);
      end
    end
  end

endmodule

// File: doc/con_encoder_ff.md
# con_encoder_ff

Pipelined branch-condition resolver for the CON FF path. It is the encode side of the C2 condition decode. It takes the one-hot condition select produced from IR[20:19] and re-encodes it to a 2-bit condition code, checking that the select is strictly one-hot. It evaluates that condition against the bus value on a CONin strobe and holds the resulting CON flag for the control unit's conditional-branch step. It also keeps sticky error and taken/not-taken statistics for branch debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of bus_data; the sign bit is bus_data[DATA_WIDTH-1].
- CNT_WIDTH, 16, width of each saturating statistics counter.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- clear, input, 1, asynchronous active-high reset.
- con_in, input, 1, CONin strobe; an evaluation is accepted on any rising edge where it is high.
- cond_onehot, input, 4, condition select: 0001 = zero, 0010 = nonzero, 0100 = positive, 1000 = negative.
- bus_data, input, DATA_WIDTH, bus value to test; sampled with con_in.
- err_ack, input, 1, synchronously clears onehot_error.
- counter_clr, input, 1, synchronously zeroes both counters.
- con_out, output, 1, registered CON flag (branch taken).
- cond_code, output, 2, registered encoded condition: 00 zero, 01 nonzero, 10 positive, 11 negative.
- code_valid, output, 1, high when the last accepted cond_onehot was strictly one-hot.
- done, output, 1, one-cycle pulse when con_out reflects a new evaluation.
- onehot_error, output, 1, sticky flag set by a non-one-hot select.
- taken_count, output, CNT_WIDTH, saturating count of evaluations with con_out = 1.
- not_taken_count, output, CNT_WIDTH, saturating count of valid evaluations with con_out = 0.

## Operation
Stage 1 (capture), on an edge with con_in = 1:
- Encode cond_onehot into code_r.
- valid_r = 1 iff exactly one bit of cond_onehot is set.
- z_r = 1 iff bus_data == 0.
- n_r = bus_data[DATA_WIDTH-1].
- s1_v = 1. On an edge with con_in = 0, s1_v = 0 and the other stage-1 registers hold.

Invalid select (0000, or two or more bits set):
- code_r = 00 and valid_r = 0.
- onehot_error is set on the same edge.

Stage 2 (resolve), on an edge with s1_v = 1:
- con_out = valid_r AND cond(code_r), where:
  - 00 → z_r
  - 01 → NOT z_r
  - 10 → NOT n_r (zero counts as positive)
  - 11 → n_r
- cond_code ← code_r and code_valid ← valid_r.
- done = 1 for that one cycle.
- Exactly one counter increments (unless saturated): taken_count if con_out = 1, not_taken_count if valid_r = 1 and con_out = 0. Invalid evaluations increment neither.

Stage 2 when s1_v = 0:
- con_out, cond_code and code_valid hold their values.
- done = 0.

Counters:
- Each stops at all-ones and does not wrap.
- counter_clr has priority over an increment in the same cycle.

onehot_error:
- Set by an invalid capture; cleared by err_ack.
- If set and err_ack occur on the same edge, set wins and the flag stays 1.

Reset (clear high, asynchronous) drives all of the following to 0 immediately, including mid-evaluation:
- Stage-1 registers and s1_v.
- con_out, cond_code (00), code_valid, done, onehot_error, taken_count, not_taken_count.
- A pending stage-1 evaluation is discarded: no done pulse and no counter update.

## Timing
- Latency: con_in sampled at edge N → con_out, cond_code, code_valid, done and the counters update at edge N+1. onehot_error updates at edge N.
- Throughput: one evaluation per cycle. Back-to-back con_in strobes produce back-to-back done pulses, and con_out may change every cycle.
- No backpressure: the consumer must sample con_out while done is high, or on any later cycle before the next done.
- Inputs sampled only at edges where con_in = 1. bus_data and cond_onehot are don't-care otherwise.
- First edge after clear deasserts: a capture is allowed. done cannot assert before the second edge.

## Test plan
- Reset: assert clear mid-pipeline (con_in accepted the previous edge) → all outputs 0 immediately, no done pulse after release, counters stay 0.
- All four conditions: bus = 0, 5, 0x80000000, each with each select → con_out matches:
  - 0001: 1, 0, 0
  - 0010: 0, 1, 1
  - 0100: 1, 1, 0
  - 1000: 0, 0, 1
  - cond_code 00/01/10/11, done one cycle after each con_in.
- Back-to-back: con_in high 4 consecutive cycles with selects 0001, 0010, 0100, 1000 and bus = 0 → done high 4 consecutive cycles, con_out sequence 1, 0, 1, 0, taken_count = 2, not_taken_count = 2.
- Invalid select: cond_onehot = 0110 then 0000 → con_out = 0, code_valid = 0, cond_code = 00, onehot_error = 1, counters unchanged. err_ack in the same cycle as a new 1100 capture → onehot_error stays 1; err_ack alone → 0.
- Saturation: preload taken_count = 0xFFFE, issue 3 taken evaluations → 0xFFFF and holds. Assert counter_clr together with a taken evaluation → count 0.
- Idle hold: after con_out = 1, toggle bus_data and cond_onehot with con_in = 0 for 10 cycles → con_out, cond_code and code_valid unchanged, done stays 0.
